// File: rtl/seven_seg_pkg.sv
// Shared constants and the digit-code to segment-glyph mapping for the
// seven-segment scanner. Glyphs are active-low, ordered a..g (index 0 = a).
package seven_seg_pkg;

    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [0:6] SEG_OFF   = 7'b1111111;
    localparam logic [0:6] SEG_MINUS = 7'b1111110;

    // Translate a 4-bit digit code into its active-low a..g pattern.
    // Codes 11..15 fall through to the all-off glyph.
    function automatic logic [0:6] seg_decode(input logic [3:0] code);
        logic [0:6] seg;
        case (code)
            4'd0:       seg = 7'b0000001;
            4'd1:       seg = 7'b1001111;
            4'd2:       seg = 7'b0010010;
            4'd3:       seg = 7'b0000110;
            4'd4:       seg = 7'b1001100;
            4'd5:       seg = 7'b0100100;
            4'd6:       seg = 7'b0100000;
            4'd7:       seg = 7'b0001111;
            4'd8:       seg = 7'b0000000;
            4'd9:       seg = 7'b0000100;
            CODE_MINUS: seg = SEG_MINUS;
            default:    seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Frame-load / brightness bus and display pins of the seven-segment scanner.
// The master drives frame data and brightness; the slave is the scanner.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 3
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lead;
    logic [BRIGHT_W-1:0]     brightness;

    logic [0:6]              segments;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   anode_active;
    logic                    frame_done;

    modport master (
        output load, digits_in, dp_in, blank_lead, brightness,
        input  segments, dp_n, anode_active, frame_done
    );

    modport slave (
        input  load, digits_in, dp_in, blank_lead, brightness,
        output segments, dp_n, anode_active, frame_done
    );
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational code-to-segments decoder used on the currently scanned digit.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [0:6] seg
);

    assign seg = seg_decode(code);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver. A shadow frame is
// loaded at any time and copied into the displayed frame only at a frame
// boundary, so a frame is never shown half old / half new. Leading-zero
// blanking is resolved once at commit time; brightness is a PWM window
// inside each digit slot, with p = 0 kept dark as a ghosting guard.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    seven_seg_scanner_if.slave bus
);

    localparam int P_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int ON_W  = P_W + 1;

    localparam logic [P_W-1:0]   P_LAST   = P_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ON_W-1:0]  ON_STEP  = ON_W'(REFRESH_DIV >> BRIGHT_W);

    // Scan counters
    logic [P_W-1:0]   p_r;
    logic [IDX_W-1:0] idx_r;
    logic             p_wrap_s;
    logic             boundary_s;

    // Shadow and committed frames
    logic [NUM_DIGITS-1:0][3:0] shadow_codes_r;
    logic [NUM_DIGITS-1:0]      shadow_dp_r;
    logic                       shadow_blank_r;
    logic                       pending_r;
    logic [NUM_DIGITS-1:0][3:0] commit_codes_r;
    logic [NUM_DIGITS-1:0]      commit_dp_r;
    logic [NUM_DIGITS-1:0]      commit_mask_r;

    // Commit source selection
    logic [NUM_DIGITS-1:0][3:0] sel_codes_s;
    logic [NUM_DIGITS-1:0]      sel_dp_s;
    logic                       sel_blank_s;
    logic                       do_commit_s;

    // Per-slot datapath
    logic [ON_W-1:0]       bright_plus_s;
    logic [ON_W-1:0]       on_cycles_s;
    logic [3:0]            dec_code_s;
    logic [0:6]            dec_seg_s;
    logic [NUM_DIGITS-1:0] anode_next_s;

    // Output registers
    logic [0:6]            seg_r;
    logic                  dp_n_r;
    logic [NUM_DIGITS-1:0] anode_r;

    // Blank every code-0 digit from the top down until the first non-zero
    // code; digit 0 is always left visible.
    function automatic logic [NUM_DIGITS-1:0] lead_mask(
        input logic [NUM_DIGITS-1:0][3:0] codes,
        input logic                       enable
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  zero_run;
        mask     = {NUM_DIGITS{1'b0}};
        zero_run = enable;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (codes[k] == 4'd0);
            mask[k]  = zero_run;
        end
        return mask;
    endfunction

    assign p_wrap_s   = (p_r == P_LAST);
    assign boundary_s = p_wrap_s && (idx_r == IDX_LAST);

    // Advance the prescaler every cycle and the digit index on prescaler wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r   <= {P_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (p_wrap_s) begin
            p_r   <= {P_W{1'b0}};
            idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
            p_r   <= p_r + P_W'(1);
            idx_r <= idx_r;
        end
    end

    // Capture a new frame into the shadow on every load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_codes_r <= {NUM_DIGITS{CODE_BLANK}};
            shadow_dp_r    <= {NUM_DIGITS{1'b0}};
            shadow_blank_r <= 1'b0;
        end else if (bus.load) begin
            shadow_codes_r <= bus.digits_in;
            shadow_dp_r    <= bus.dp_in;
            shadow_blank_r <= bus.blank_lead;
        end else begin
            shadow_codes_r <= shadow_codes_r;
            shadow_dp_r    <= shadow_dp_r;
            shadow_blank_r <= shadow_blank_r;
        end
    end

    // Track whether the shadow holds data not yet shown; a load landing on
    // the boundary is committed directly and so never leaves it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
        end else if (boundary_s) begin
            pending_r <= 1'b0;
        end else if (bus.load) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Choose what the boundary commits: live inputs bypass the shadow when
    // a load coincides with the boundary, otherwise the pending shadow.
    always_comb begin
        sel_codes_s = shadow_codes_r;
        sel_dp_s    = shadow_dp_r;
        sel_blank_s = shadow_blank_r;
        do_commit_s = 1'b0;
        if (boundary_s && bus.load) begin
            sel_codes_s = bus.digits_in;
            sel_dp_s    = bus.dp_in;
            sel_blank_s = bus.blank_lead;
            do_commit_s = 1'b1;
        end else if (boundary_s && pending_r) begin
            do_commit_s = 1'b1;
        end else begin
            do_commit_s = 1'b0;
        end
    end

    // Update the displayed frame and its blank mask at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_codes_r <= {NUM_DIGITS{CODE_BLANK}};
            commit_dp_r    <= {NUM_DIGITS{1'b0}};
            commit_mask_r  <= {NUM_DIGITS{1'b0}};
        end else if (do_commit_s) begin
            commit_codes_r <= sel_codes_s;
            commit_dp_r    <= sel_dp_s;
            commit_mask_r  <= lead_mask(sel_codes_s, sel_blank_s);
        end else begin
            commit_codes_r <= commit_codes_r;
            commit_dp_r    <= commit_dp_r;
            commit_mask_r  <= commit_mask_r;
        end
    end

    // Pick the scanned digit's code (forced blank if masked) and compute
    // the anode pattern for the PWM window 1 <= p < on_cycles.
    always_comb begin
        dec_code_s    = commit_codes_r[idx_r];
        bright_plus_s = ON_W'(bus.brightness) + ON_W'(1);
        on_cycles_s   = bright_plus_s * ON_STEP;
        anode_next_s  = {NUM_DIGITS{1'b1}};
        if (commit_mask_r[idx_r]) begin
            dec_code_s = CODE_BLANK;
        end else begin
            dec_code_s = commit_codes_r[idx_r];
        end
        if ((p_r != {P_W{1'b0}}) && ({1'b0, p_r} < on_cycles_s)) begin
            anode_next_s = ~(NUM_DIGITS'(1) << idx_r);
        end else begin
            anode_next_s = {NUM_DIGITS{1'b1}};
        end
    end

    seven_seg_decode u_decode (
        .code (dec_code_s),
        .seg  (dec_seg_s)
    );

    // Register the pin values one cycle after the p/idx that select them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r   <= SEG_OFF;
            dp_n_r  <= 1'b1;
            anode_r <= {NUM_DIGITS{1'b1}};
        end else begin
            seg_r   <= dec_seg_s;
            dp_n_r  <= ~commit_dp_r[idx_r];
            anode_r <= anode_next_s;
        end
    end

    assign bus.segments     = seg_r;
    assign bus.dp_n         = dp_n_r;
    assign bus.anode_active = anode_r;
    assign bus.frame_done   = boundary_s;

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for a common-anode seven-segment display of `NUM_DIGITS` digits. It holds a frame of 4-bit digit codes and scans them onto a shared active-low segment bus, one digit slot at a time, with per-digit decimal points. It adds leading-zero blanking, a minus-sign glyph, PWM brightness and tear-free frame updates. It sits between the signed-multiplier result/BCD logic and the board display pins, and replaces the single-digit combinational decoder.

## Interface
- `NUM_DIGITS`, default 4: number of digits and anodes, at least 2.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot. Must be a multiple of 2^`BRIGHT_W`.
- `BRIGHT_W`, default 3: width of the brightness control.
- `clk` input 1: the single clock for the block.
- `rst_n` input 1: reset, asynchronous and active-low.
- `load` input 1: one-cycle strobe that captures `digits_in`, `dp_in` and `blank_lead`.
- `digits_in` input 4*`NUM_DIGITS`: digit codes. Bits [3:0] are digit 0, the rightmost digit.
- `dp_in` input `NUM_DIGITS`: decimal point per digit, 1 = lit.
- `blank_lead` input 1: enables leading-zero blanking.
- `brightness` input `BRIGHT_W`: sampled live; 0 is dimmest, all-ones is brightest.
- `segments` output [0:6]: active-low segments; bit 0 = a through bit 6 = g. Registered.
- `dp_n` output 1: active-low decimal point. Registered.
- `anode_active` output `NUM_DIGITS`: active-low one-hot anodes; bit k drives digit k. Registered.
- `frame_done` output 1: one-cycle pulse at each frame boundary.

## Operation
**Digit codes**
- Codes 0–9 display the decimal digit, using the standard patterns (0 = 0000001, 8 = 0000000).
- Code 10 is minus (1111110). Codes 11–15 are blank (1111111).

**Storage**
- Shadow register: written on `load`; sets the `pending` flag.
- Committed register: drives the display. Updated from shadow only at a frame boundary while `pending` is set; the commit clears `pending`.
- Several loads within one frame: the last one wins.

**Scan counters**
- Prescaler `p` counts 0..`REFRESH_DIV`-1 and wraps.
- Digit index `idx` increments when `p` wraps, counting 0..`NUM_DIGITS`-1 and wrapping to 0.
- Frame boundary is the cycle where `p` = `REFRESH_DIV`-1 and `idx` = `NUM_DIGITS`-1. `frame_done` pulses on that cycle.

**Leading-zero blanking**
- The blank mask is computed at commit time from the incoming data.
- Scanning from the most significant digit downward, each code-0 digit is blanked until the first non-zero code. Minus and blank codes count as non-zero.
- Digit 0 is never blanked, so an all-zero frame shows a single 0.
- The decimal point of a blanked digit is still shown if its `dp_in` bit is 1.

**Brightness PWM and ghost guard**
- `on_cycles` = (`brightness`+1) * (`REFRESH_DIV` >> `BRIGHT_W`).
- Anode `idx` is driven low only while 1 ≤ `p` < `on_cycles`.
- At `p` = 0 all anodes are high. This is the ghost guard while segments change.
- `segments` and `dp_n` follow the current digit for the whole slot.

## Timing
- **Reset values:** `segments` = 1111111, `dp_n` = 1, `anode_active` all 1, `frame_done` = 0.
- **Reset internal state:** `p` = 0, `idx` = 0, `pending` = 0, shadow and committed registers all code 15 with `dp` = 0.
- **Output latency:** outputs are registered, one cycle after the `p`/`idx` values that select them.
- **Load latency:** `load` at cycle t is visible in shadow at t+1. It first appears on the pins in the slot for digit 0 after the next frame boundary.
- **Load on the boundary cycle:** the data loaded in that same cycle is committed directly (bypass), and `pending` stays 0.
- **Reset mid-frame:** all outputs go immediately (asynchronously) to their reset values. Scanning restarts at `idx` = 0, `p` = 0 after `rst_n` deasserts.
- **Brightness change:** takes effect on the next cycle's compare; no resynchronisation.

## Structure
- Package `seven_seg_pkg` holds:
  - constants `CODE_MINUS` = 10 and `CODE_BLANK` = 15;
  - segment constants `SEG_OFF` = 1111111 and `SEG_MINUS`;
  - function `seg_decode(code)`, returning a 7-bit value in a..g order.
- Sub-module `seven_seg_decode`: purely combinational code-to-segments decoder, instantiated once on the selected digit.
- The scanner holds the counters, the shadow/commit logic, the blank mask and the output registers.

## Test plan
Bench parameters: `NUM_DIGITS` = 4, `REFRESH_DIV` = 8, `BRIGHT_W` = 2.
- **Reset:** assert `rst_n` = 0 mid-slot → `segments` = 1111111, `anode_active` = 1111 and `dp_n` = 1 the same cycle; after release, the first low anode is 1110.
- **Basic frame:** `load` 0x1234 with `brightness` = 3 → after the boundary, anode 1110 shows 1001100 (4), 1101 shows 0000110 (3), 1011 shows 0010010 (2), 0111 shows 1001111 (1). Anodes are low for `p` = 1..7 and high at `p` = 0.
- **Leading-zero blanking:** `load` 0x0052 with `blank_lead` = 1 → digits 3 and 2 show 1111111, digit 1 shows 0100100 (5), digit 0 shows 0010010 (2). Then `load` 0x0000 → only digit 0 shows 0000001. Then `load` 0xA007 → digit 3 shows minus, digits 2 and 1 show 0 (not blanked).
- **Brightness:** `brightness` = 0 → each anode is low only at `p` = 1, one cycle per 8-cycle slot. `brightness` = 1 → low at `p` = 1..3.
- **Tear-free update:** `load` 0x1111 during the digit-1 slot, then `load` 0x2222 in the digit-2 slot → the current frame is unchanged; the next frame shows all 2s; `frame_done` pulses once per 32 cycles.
- **Boundary bypass:** `load` asserted exactly on the `frame_done` cycle → that data displays from the next digit-0 slot, and `pending` reads 0 afterward.
